ucie_sb_tx_serializer: RTL
==========================

# ucie_sb_tx_serializer

Parametrised UCIe sideband transmit serializer for the SBTX path. It arbitrates packets from NUM_CH client channels and shifts them out LSB-first on SBTX_DATA, with a forwarded-clock enable that is high only during the packet bits. By construction it enforces the sideband line rules: PKT_W-UI bursts, a programmable minimum inter-packet gap of at least MIN_GAP_UI, and clock and data held low in reset. Unlike a passive checker, it generates compliant traffic and provides packet accounting.

## Interface
Clock is `clk`; reset is `reset`, synchronous and active-high.

Parameters:
- NUM_CH, 4: number of client channels (≥1)
- PKT_W, 64: packet width in UI (≥2)
- MIN_GAP_UI, 32: hard floor on idle UI between packets (≥2)
- GAP_W, 8: width of gap_cfg
- CNT_W, 16: width of pkt_count
- CH_W, max(1,$clog2(NUM_CH)): channel index width

Ports:
- clk  in  1  UI clock (800 MHz); source of the forwarded clock
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_CH  per-channel packet valid
- in_ready  out  NUM_CH  per-channel accept, one-hot or zero
- in_data  in  NUM_CH*PKT_W  channel c occupies bits [c*PKT_W +: PKT_W]
- gap_cfg  in  GAP_W  requested gap in UI
- SBTX_DATA  out  1  serial data, registered
- sbtx_clk_en  out  1  forwarded-clock enable, registered; SBTX_CLK = clk gated externally by this signal
- busy  out  1  FSM not in IDLE
- pkt_count  out  CNT_W  completed packets, wraps
- last_ch  out  CH_W  channel of the most recently accepted packet

## Operation
- FSM states:
  - IDLE: waits for any in_valid.
  - SHIFT: drives PKT_W UI of data.
  - GAP: holds the line idle.
- IDLE, any in_valid set:
  - Round-robin grant g goes to the first valid channel after rr_ptr (circular).
  - in_ready[g]=1 combinationally in that cycle only. Handshake = valid & ready.
  - Data is loaded into the shift register, rr_ptr←g, last_ch←g, next state SHIFT.
- in_ready is 0 in every state except IDLE.
- Clients hold in_valid and in_data stable until accepted; dropping valid before acceptance is legal and the channel is simply skipped.
- SHIFT:
  - Each cycle: SBTX_DATA=shreg[0], sbtx_clk_en=1, shreg shifts right.
  - After exactly PKT_W cycles, go to GAP.
  - pkt_count increments at the edge ending the last SHIFT cycle, wrapping modulo 2^CNT_W.
- Effective gap G = max(MIN_GAP_UI, gap_cfg), sampled at the edge ending the last SHIFT cycle. gap_cfg changes during GAP have no effect on the current gap.
- GAP: lasts G−1 cycles, then IDLE. The IDLE cycle(s) also hold sbtx_clk_en=0. Minimum enable-low run between packets is therefore exactly G UI.
- Outside SHIFT: SBTX_DATA=0 and sbtx_clk_en=0.
- busy=1 in SHIFT and GAP.

## Timing
- Reset values:
  - SBTX_DATA=0, sbtx_clk_en=0, in_ready=0, busy=1.
  - pkt_count=0, last_ch=0.
  - rr_ptr=NUM_CH−1, so ch0 has first priority.
  - FSM=GAP with a counter giving MIN_GAP_UI−1 GAP cycles.
- After reset, with cycle 0 = first cycle with reset low:
  - earliest in_ready is cycle MIN_GAP_UI−1;
  - earliest sbtx_clk_en=1 is cycle MIN_GAP_UI.
- Latency: the handshake in cycle t produces bit0 on SBTX_DATA with sbtx_clk_en=1 in cycle t+1; the last bit is in cycle t+PKT_W.
- Back-to-back throughput: one packet per PKT_W+G cycles.
- Reset asserted mid-SHIFT:
  - outputs go to 0 at the next edge;
  - the partial packet is discarded and not counted;
  - the post-reset gap above applies, so no gap shorter than MIN_GAP_UI ever appears.
- Reset dominates all other inputs in the same cycle.
- gap_cfg < MIN_GAP_UI, including 0: G=MIN_GAP_UI. gap_cfg = 2^GAP_W−1 is honoured exactly.
- NUM_CH=1: arbiter degenerates and last_ch stays 0.
- in_valid arriving during SHIFT or GAP: held off, accepted in the first IDLE cycle.

## Test plan
- Single packet, defaults:
  - Stimulus: ch0 data 64'h0123_4567_89AB_CDEF, gap_cfg=0, presented at reset release.
  - Response: in_ready at cycle 31; 64 enabled UI with bits LSB-first (1,1,1,1,0,1,1,1,…); then ≥32 disabled UI; pkt_count=1, last_ch=0.
- Round robin:
  - Stimulus: all 4 channels valid continuously.
  - Response: grant order 0,1,2,3,0,1; packet period 96 cycles; each channel's data is emitted intact.
- Programmable gap:
  - Stimulus: gap_cfg=40 for packet 1, changed to 5 during its GAP.
  - Response: gap after packet 1 is 40 UI; gap after packet 2 is 32 UI.
- Reset mid-packet:
  - Stimulus: assert reset for 1 cycle at bit 20.
  - Response: SBTX_DATA and sbtx_clk_en are 0 the next cycle; pkt_count is unchanged at 0; next sbtx_clk_en rises exactly 32 cycles after reset drops.
- Counter wrap (CNT_W=4):
  - Stimulus: 17 packets.
  - Response: pkt_count reads 15, then 0, then 1.
- Valid withdrawal:
  - Stimulus: ch2 valid during SHIFT, dropped before IDLE, with ch3 valid.
  - Response: ch2 is never granted and ch3 is granted next.

Source files
------------

// File: rtl/ucie_sb_tx_serializer.sv
// UCIe sideband TX serializer: round-robin arbitration of NUM_CH packets, shifted out LSB-first with forwarded-clock enable.
// Handshake in cycle t gives bit0 in t+1; in_ready only in IDLE, so clients are stalled through SHIFT and the enforced gap.
module ucie_sb_tx_serializer #(
   parameter int NUM_CH     = 4,
   parameter int PKT_W      = 64,
   parameter int MIN_GAP_UI = 32,
   parameter int GAP_W      = 8,
   parameter int CNT_W      = 16,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         in_valid,
   output logic [NUM_CH-1:0]         in_ready,
   input  logic [NUM_CH*PKT_W-1:0]   in_data,
   input  logic [GAP_W-1:0]          gap_cfg,
   output logic                      SBTX_DATA,
   output logic                      sbtx_clk_en,
   output logic                      busy,
   output logic [CNT_W-1:0]          pkt_count,
   output logic [CH_W-1:0]           last_ch
);

   localparam int GAP_MAX = (1 << GAP_W) - 1;
   localparam int TMAX_A  = (PKT_W > MIN_GAP_UI) ? PKT_W : MIN_GAP_UI;
   localparam int TMAX    = (TMAX_A > GAP_MAX) ? TMAX_A : GAP_MAX;
   localparam int TW      = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t             r_state;
   logic [TW-1:0]      r_cnt;
   logic [PKT_W-1:0]   r_shreg;
   logic [CH_W-1:0]    r_rr_ptr;
   logic [CH_W-1:0]    r_last_ch;
   logic               r_sbtx_data;
   logic               r_clk_en;
   logic [CNT_W-1:0]   r_pkt_count;

   logic               w_grant_vld;
   logic [CH_W-1:0]    w_grant;
   logic [CH_W-1:0]    w_idx;
   logic [PKT_W-1:0]   w_grant_dat;
   logic               w_accept;
   logic [TW-1:0]      w_gap_eff;

   // First valid channel strictly after the last winner, wrapping around.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = '0;
      w_idx       = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
         if (!w_grant_vld && in_valid[w_idx]) begin
            w_grant_vld = 1'b1;
            w_grant     = w_idx;
         end
      end
   end

   always_comb begin
      w_grant_dat = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_grant == CH_W'(c)) begin
            w_grant_dat = in_data[c*PKT_W +: PKT_W];
         end
      end
   end

   assign w_accept  = (r_state == S_IDLE) && !reset && w_grant_vld;
   assign w_gap_eff = (TW'(gap_cfg) > TW'(MIN_GAP_UI)) ? TW'(gap_cfg) : TW'(MIN_GAP_UI);

   // r_cnt counts down to zero in SHIFT (PKT_W cycles) and GAP (G-1 cycles).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_GAP;
         r_cnt       <= TW'(MIN_GAP_UI - 2);
         r_shreg     <= '0;
         r_rr_ptr    <= CH_W'(NUM_CH - 1);
         r_last_ch   <= '0;
         r_sbtx_data <= 1'b0;
         r_clk_en    <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_SHIFT;
                  r_cnt       <= TW'(PKT_W - 1);
                  r_shreg     <= w_grant_dat >> 1;
                  r_sbtx_data <= w_grant_dat[0];
                  r_clk_en    <= 1'b1;
                  r_rr_ptr    <= w_grant;
                  r_last_ch   <= w_grant;
               end
            end
            S_SHIFT: begin
               if (r_cnt == '0) begin
                  r_state     <= S_GAP;
                  r_cnt       <= w_gap_eff - TW'(2);
                  r_sbtx_data <= 1'b0;
                  r_clk_en    <= 1'b0;
                  r_pkt_count <= r_pkt_count + CNT_W'(1);
               end else begin
                  r_cnt       <= r_cnt - TW'(1);
                  r_sbtx_data <= r_shreg[0];
                  r_shreg     <= r_shreg >> 1;
               end
            end
            S_GAP: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - TW'(1);
               end
            end
            default: begin
               r_state     <= S_GAP;
               r_cnt       <= TW'(MIN_GAP_UI - 2);
               r_sbtx_data <= 1'b0;
               r_clk_en    <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = w_accept ? (NUM_CH'(1) << w_grant) : '0;
   assign SBTX_DATA   = r_sbtx_data;
   assign sbtx_clk_en = r_clk_en;
   assign busy        = (r_state != S_IDLE);
   assign pkt_count   = r_pkt_count;
   assign last_ch     = r_last_ch;

endmodule
